// File: rtl/nibble_serial_adder_seq_if.sv
// Operand/result handshake bundle for nibble_serial_adder_seq.
// The optional sub field exists only when SUBTRACT_EN is defined.
interface nibble_serial_adder_seq_if #(
  parameter int unsigned WIDTH = 16
);
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Upstream/downstream side: drives operands, consumes results.
  modport master (
`ifdef SUBTRACT_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Sequencer side.
  modport slave (
`ifdef SUBTRACT_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder_seq.sv
// Serial WIDTH-bit adder sequencer driving an external 4-bit adder slice,
// one nibble per clock, with valid/ready handshakes on both sides.
// Optional feature macro: SUBTRACT_EN (adds bus.sub; sub=1 computes a-b).
module nibble_serial_adder_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  nibble_serial_adder_seq_if.slave         bus,
  output logic                             busy,
  output logic [3:0]                       add_a,
  output logic [3:0]                       add_b,
  output logic                             add_cin,
  input  logic [3:0]                       add_sum,
  input  logic                             add_cout
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_shift, b_shift;
  logic               accept;

  // Current operand nibbles selected by shifting rather than indexing.
  assign a_shift = a_q >> {idx_q, 2'b00};
  assign b_shift = b_q >> {idx_q, 2'b00};

  assign bus.in_ready  = (state_q == StIdle) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign busy          = (state_q != StIdle);
  assign accept        = bus.in_valid & bus.in_ready;

  // Next-state, datapath updates and adder-slice drive.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = bus.a;
          idx_d   = '0;
`ifdef SUBTRACT_EN
          // Two's-complement subtract: invert B and force carry-in.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        add_a   = a_shift[3:0];
        add_b   = b_shift[3:0];
        add_cin = carry_q;
        sum_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d      = add_cout;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
